// File: rtl/frame_rd_checker.sv
// Raster read-side checker for the SDRAM frame buffer: drives read-FIFO rd_en per line
// and compares returned words against the per-line ramp 1..H_ACTIVE.
module frame_rd_checker #(
    parameter int H_ACTIVE = 400,
    parameter int H_BLANK  = 624,
    parameter int V_LINES  = 480,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_done,
    input  logic        start,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic        busy,
    output logic        frame_done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [9:0]  first_err_x,
    output logic [8:0]  first_err_y
);

    localparam logic [9:0]  X_LAST     = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  Y_LAST     = 9'(V_LINES - 1);
    localparam logic [15:0] BLANK_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] LAT_LAST   = 16'(RD_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACTIVE, S_HBLANK, S_DRAIN} state_t;

    state_t      state_q;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic [15:0] cnt_q;
    logic        rd_en_q, busy_q, done_q, pass_q, armed_q;
    logic [15:0] err_q, err_d;
    logic [9:0]  fx_q;
    logic [8:0]  fy_q;

    // {valid, x, y} delayed to line up with the returning rd_data word
    logic [RD_LAT-1:0]       pv_q;
    logic [RD_LAT-1:0][9:0]  px_q;
    logic [RD_LAT-1:0][8:0]  py_q;

    logic [15:0] expected;
    logic        mism;

    always_comb begin
        expected = {6'd0, px_q[RD_LAT-1]} + 16'd1;
        mism     = pv_q[RD_LAT-1] && (rd_data != expected);
        err_d    = err_q;
        if (mism && (err_q != 16'hFFFF))
            err_d = err_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            armed_q <= 1'b0;
            err_q   <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            pv_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            // armed_q masks a start arriving on the first cycle out of reset
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            pv_q[0] <= rd_en_q;
            px_q[0] <= x_q;
            py_q[0] <= y_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                px_q[i] <= px_q[i-1];
                py_q[i] <= py_q[i-1];
            end
            err_q <= err_d;
            if (mism && (err_q == 16'd0)) begin
                fx_q <= px_q[RD_LAT-1];
                fy_q <= py_q[RD_LAT-1];
            end

            case (state_q)
                S_IDLE: begin
                    if (start && armed_q) begin
                        state_q <= S_WAIT;
                        busy_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        fx_q    <= '0;
                        fy_q    <= '0;
                    end
                end
                S_WAIT: begin
                    if (init_done) begin
                        state_q <= S_ACTIVE;
                        x_q     <= '0;
                        y_q     <= '0;
                        rd_en_q <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (x_q == X_LAST) begin
                        x_q <= '0;
                        if (y_q == Y_LAST) begin
                            state_q <= S_DRAIN;
                            cnt_q   <= '0;
                            rd_en_q <= 1'b0;
                        end else if (H_BLANK == 0) begin
                            y_q <= y_q + 9'd1;
                        end else begin
                            state_q <= S_HBLANK;
                            cnt_q   <= '0;
                            rd_en_q <= 1'b0;
                        end
                    end else begin
                        x_q <= x_q + 10'd1;
                    end
                end
                S_HBLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= S_ACTIVE;
                        y_q     <= y_q + 9'd1;
                        rd_en_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DRAIN: begin
                    // last compare lands on the exit edge, so pass uses err_d
                    if (cnt_q == LAT_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 16'd0);
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_en       = rd_en_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign pass        = pass_q;
    assign err_cnt     = err_q;
    assign first_err_x = fx_q;
    assign first_err_y = fy_q;

endmodule

// File: tb/tb_frame_rd_checker.sv
// Bench for frame_rd_checker: three configurations fed by a FIFO model that replays
// the writer's ramp with chosen corruptions; results compared against frame-level expectations.
module tb_frame_rd_checker;

    localparam int HA [3] = '{8, 8, 400};
    localparam int HB [3] = '{4, 4, 0};
    localparam int VL [3] = '{3, 3, 200};
    localparam int LT [3] = '{1, 3, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a [3];
    logic        init_a  [3];
    logic        rd_en_a [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic        pass_a  [3];
    logic [15:0] err_a   [3];
    logic [9:0]  fx_a    [3];
    logic [8:0]  fy_a    [3];

    logic [31:0] bad_map [3];
    bit          bad_all [3];

    int n_chk = 0;
    int n_fail = 0;

    // Words the writer stored, with optional corruption (0 never matches a ramp value)
    function automatic logic [15:0] fifo_word(input int g, input int k);
        int x = k % HA[g];
        if (bad_all[g] || (k < 32 && bad_map[g][k]))
            return 16'd0;
        return 16'(x + 1);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        logic [3:0][15:0] pipe;
        int               pops;
        always @(posedge clk) begin
            if (!rst_n)
                pops <= 0;
            else if (rd_en_a[g])
                pops <= (pops + 1) % (HA[g] * VL[g]);
            pipe <= {pipe[2:0], rd_en_a[g] ? fifo_word(g, pops) : 16'($urandom)};
        end

        frame_rd_checker #(
            .H_ACTIVE(HA[g]), .H_BLANK(HB[g]), .V_LINES(VL[g]), .RD_LAT(LT[g])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .init_done  (init_a[g]),
            .start      (start_a[g]),
            .rd_en      (rd_en_a[g]),
            .rd_data    (pipe[LT[g]-1]),
            .busy       (busy_a[g]),
            .frame_done (done_a[g]),
            .pass       (pass_a[g]),
            .err_cnt    (err_a[g]),
            .first_err_x(fx_a[g]),
            .first_err_y(fy_a[g])
        );
    end

    // Raster monitor: rd_en run lengths, blanking gaps, rd_en outside busy
    int cyc = 0;
    int rd_total [3] = '{0, 0, 0};
    int done_total [3] = '{0, 0, 0};
    int last_rd [3] = '{0, 0, 0};
    int done_at [3] = '{0, 0, 0};
    int perr [3] = '{0, 0, 0};
    int bursts [3] = '{0, 0, 0};
    int run [3] = '{0, 0, 0};
    int gap [3] = '{0, 0, 0};
    bit gv [3];

    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < 3; g++) begin
            if (rd_en_a[g]) begin
                rd_total[g]++;
                last_rd[g] = cyc;
                if (!busy_a[g]) perr[g]++;
            end
            if (done_a[g]) begin
                done_total[g]++;
                done_at[g] = cyc;
            end
            if (HB[g] > 0) begin
                if (rd_en_a[g]) begin
                    if (run[g] == 0 && gv[g] && gap[g] != HB[g]) perr[g]++;
                    run[g]++;
                    gap[g] = 0;
                end else begin
                    if (run[g] != 0) begin
                        if (run[g] != HA[g]) perr[g]++;
                        bursts[g]++;
                        gv[g] = 1'b1;
                    end
                    run[g] = 0;
                    gap[g]++;
                end
                if (!busy_a[g]) begin
                    gv[g]  = 1'b0;
                    gap[g] = 0;
                end
            end
        end
    end

    int d_rd, d_done, d_perr, d_bursts;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int g);
        start_a[g] = 1'b1;
        tick();
        start_a[g] = 1'b0;
    endtask

    task automatic run_frame(input int g, input int init_delay, input int budget);
        int rd0 = rd_total[g];
        int dn0 = done_total[g];
        int pe0 = perr[g];
        int bu0 = bursts[g];
        init_a[g] = (init_delay == 0);
        pulse_start(g);
        if (init_delay > 0) begin
            tick(init_delay);
            init_a[g] = 1'b1;
        end
        for (int i = 0; i < budget && done_total[g] == dn0; i++) tick();
        tick(4);
        d_rd     = rd_total[g] - rd0;
        d_done   = done_total[g] - dn0;
        d_perr   = perr[g] - pe0;
        d_bursts = bursts[g] - bu0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        for (int g = 0; g < 3; g++) begin
            n_chk++;
            if ({rd_en_a[g], busy_a[g], done_a[g], pass_a[g], err_a[g], fx_a[g], fy_a[g]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got rd_en=%b busy=%b done=%b pass=%b err=%0d fx=%0d fy=%0d want all 0",
                         g, rd_en_a[g], busy_a[g], done_a[g], pass_a[g], err_a[g], fx_a[g], fy_a[g]);
            end
        end
        // start coincident with reset release must be dropped
        rst_n = 1'b1;
        start_a[0] = 1'b1;
        tick();
        start_a[0] = 1'b0;
        tick(3);
        n_chk++;
        if (busy_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_at_release: got busy=%b want 0", busy_a[0]);
        end
        tick(2);
    endtask

    task automatic test_ideal();
        bad_map[0] = '0;
        run_frame(0, 0, 200);
        n_chk++; if (d_rd !== 24) begin n_fail++; $display("FAIL ideal_rd_cycles: got %0d want 24", d_rd); end
        n_chk++; if (d_bursts !== 3) begin n_fail++; $display("FAIL ideal_bursts: got %0d want 3", d_bursts); end
        n_chk++; if (d_perr !== 0) begin n_fail++; $display("FAIL ideal_raster_shape: got %0d violations want 0", d_perr); end
        n_chk++; if (d_done !== 1) begin n_fail++; $display("FAIL ideal_frame_done: got %0d pulses want 1", d_done); end
        n_chk++; if (pass_a[0] !== 1'b1) begin n_fail++; $display("FAIL ideal_pass: got %b want 1", pass_a[0]); end
        n_chk++; if (err_a[0] !== 16'd0) begin n_fail++; $display("FAIL ideal_err: got %0d want 0", err_a[0]); end
        n_chk++; if (busy_a[0] !== 1'b0) begin n_fail++; $display("FAIL ideal_busy_after: got %b want 0", busy_a[0]); end
    endtask

    task automatic test_corrupt_pixel();
        bad_map[0] = 32'd1 << (1 * 8 + 5);
        run_frame(0, 0, 200);
        n_chk++; if (err_a[0] !== 16'd1) begin n_fail++; $display("FAIL corrupt_err: got %0d want 1", err_a[0]); end
        n_chk++; if (fx_a[0] !== 10'd5) begin n_fail++; $display("FAIL corrupt_x: got %0d want 5", fx_a[0]); end
        n_chk++; if (fy_a[0] !== 9'd1) begin n_fail++; $display("FAIL corrupt_y: got %0d want 1", fy_a[0]); end
        n_chk++; if (pass_a[0] !== 1'b0) begin n_fail++; $display("FAIL corrupt_pass: got %b want 0", pass_a[0]); end
        n_chk++; if (d_done !== 1) begin n_fail++; $display("FAIL corrupt_frame_done: got %0d want 1", d_done); end
    endtask

    task automatic test_init_wait();
        int bad = 0;
        int dn0 = done_total[0];
        bad_map[0] = '0;
        init_a[0]  = 1'b0;
        pulse_start(0);
        for (int i = 0; i < 50; i++) begin
            if (rd_en_a[0] !== 1'b0 || busy_a[0] !== 1'b1) bad++;
            tick();
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL init_wait_hold: got %0d bad cycles want 0", bad); end
        init_a[0] = 1'b1;
        tick();
        n_chk++; if (rd_en_a[0] !== 1'b1) begin n_fail++; $display("FAIL init_first_rd_en: got %b want 1", rd_en_a[0]); end
        for (int i = 0; i < 200 && done_total[0] == dn0; i++) tick();
        tick(2);
        n_chk++; if (pass_a[0] !== 1'b1) begin n_fail++; $display("FAIL init_wait_pass: got %b want 1", pass_a[0]); end
    endtask

    task automatic test_lat3_last_pixel();
        bad_map[1] = 32'd1 << 23;
        run_frame(1, 0, 200);
        n_chk++; if (err_a[1] !== 16'd1) begin n_fail++; $display("FAIL lat3_err: got %0d want 1", err_a[1]); end
        n_chk++; if ({fy_a[1], fx_a[1]} !== {9'd2, 10'd7}) begin n_fail++; $display("FAIL lat3_first: got (%0d,%0d) want (7,2)", fx_a[1], fy_a[1]); end
        n_chk++; if (pass_a[1] !== 1'b0) begin n_fail++; $display("FAIL lat3_pass: got %b want 0", pass_a[1]); end
        n_chk++; if (d_rd !== 24 || d_perr !== 0) begin n_fail++; $display("FAIL lat3_raster: got rd=%0d violations=%0d want 24/0", d_rd, d_perr); end
        // rd_en falls, then frame_done follows RD_LAT cycles later
        n_chk++; if (done_at[1] - last_rd[1] !== LT[1] + 1) begin n_fail++; $display("FAIL lat3_done_timing: got %0d want %0d", done_at[1] - last_rd[1], LT[1] + 1); end
    endtask

    task automatic test_saturate();
        bad_all[2] = 1'b1;
        run_frame(2, 0, 81000);
        bad_all[2] = 1'b0;
        n_chk++; if (err_a[2] !== 16'hFFFF) begin n_fail++; $display("FAIL sat_err: got %0h want ffff", err_a[2]); end
        n_chk++; if ({fy_a[2], fx_a[2]} !== 19'd0) begin n_fail++; $display("FAIL sat_first: got (%0d,%0d) want (0,0)", fx_a[2], fy_a[2]); end
        n_chk++; if (pass_a[2] !== 1'b0) begin n_fail++; $display("FAIL sat_pass: got %b want 0", pass_a[2]); end
        n_chk++; if (d_rd !== 80000) begin n_fail++; $display("FAIL sat_rd_cycles: got %0d want 80000", d_rd); end
        n_chk++; if (d_done !== 1) begin n_fail++; $display("FAIL sat_frame_done: got %0d want 1", d_done); end
    endtask

    task automatic test_reset_abort();
        int rd0 = rd_total[0];
        int dn0 = done_total[0];
        int rd1;
        bad_map[0] = '0;
        init_a[0]  = 1'b1;
        pulse_start(0);
        for (int i = 0; i < 200 && (rd_total[0] - rd0) < 19; i++) tick();
        rst_n = 1'b0;
        tick(2);
        n_chk++;
        if ({rd_en_a[0], busy_a[0], done_a[0], pass_a[0], err_a[0], fx_a[0], fy_a[0]} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got rd_en=%b busy=%b done=%b pass=%b err=%0d want all 0",
                     rd_en_a[0], busy_a[0], done_a[0], pass_a[0], err_a[0]);
        end
        rst_n = 1'b1;
        tick(10);
        n_chk++; if (done_total[0] !== dn0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", done_total[0] - dn0); end
        rd0 = rd_total[0];
        pulse_start(0);
        tick(3);
        pulse_start(0);
        tick(20);
        pulse_start(0);
        for (int i = 0; i < 200 && done_total[0] == dn0; i++) tick();
        tick(4);
        rd1 = rd_total[0];
        n_chk++; if (done_total[0] - dn0 !== 1) begin n_fail++; $display("FAIL restart_done: got %0d want 1", done_total[0] - dn0); end
        n_chk++; if (pass_a[0] !== 1'b1 || err_a[0] !== 16'd0) begin n_fail++; $display("FAIL restart_pass: got pass=%b err=%0d want 1/0", pass_a[0], err_a[0]); end
        n_chk++; if (rd1 - rd0 !== 24) begin n_fail++; $display("FAIL restart_rd_cycles: got %0d want 24", rd1 - rd0); end
        tick(10);
        n_chk++; if (rd_total[0] !== rd1 || busy_a[0] !== 1'b0) begin n_fail++; $display("FAIL restart_extra_start: got %0d extra reads busy=%b want 0/0", rd_total[0] - rd1, busy_a[0]); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int g = $urandom_range(0, 1);
            int npix = HA[g] * VL[g];
            logic [31:0] map;
            int exp_cnt;
            int first = 0;
            case ($urandom_range(0, 2))
                0: map = '0;
                1: map = 32'd1 << $urandom_range(0, npix - 1);
                default: map = $urandom & ((32'd1 << npix) - 1);
            endcase
            bad_map[g] = map;
            exp_cnt = $countones(map);
            for (int i = npix - 1; i >= 0; i--) if (map[i]) first = i;
            run_frame(g, $urandom_range(0, 5), 300);
            n_chk++; if (err_a[g] !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rand%0d_err: got %0d want %0d", it, err_a[g], exp_cnt); end
            n_chk++; if (pass_a[g] !== (exp_cnt == 0)) begin n_fail++; $display("FAIL rand%0d_pass: got %b want %b", it, pass_a[g], exp_cnt == 0); end
            n_chk++;
            if (fx_a[g] !== 10'(first % HA[g]) || fy_a[g] !== 9'(first / HA[g])) begin
                n_fail++;
                $display("FAIL rand%0d_first: got (%0d,%0d) want (%0d,%0d)", it, fx_a[g], fy_a[g], first % HA[g], first / HA[g]);
            end
            n_chk++; if (d_done !== 1 || d_rd !== npix) begin n_fail++; $display("FAIL rand%0d_frame: got done=%0d rd=%0d want 1/%0d", it, d_done, d_rd, npix); end
        end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            start_a[g] = 1'b0;
            init_a[g]  = 1'b0;
            bad_map[g] = '0;
            bad_all[g] = 1'b0;
        end
        test_reset();
        test_ideal();
        test_corrupt_pixel();
        test_init_wait();
        test_lat3_last_pixel();
        test_reset_abort();
        test_random();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #990000;
        $display("FAIL watchdog: got timeout at cycle %0d want completion", cyc);
        $fatal(1);
    end

endmodule
